seq_dtree_classifier: RTL and testbench

- Time-multiplexed, runtime-programmable decision-tree classifier for the printed-classifier flow.
- Walks a register-based node table, doing one threshold comparison per clock on MSB-truncated features, and returns a class index.
- Generalises the fixed combinational trees: tree shape, thresholds and comparison precision are loaded through a config port, not hard-wired.
- Trades latency for a single shared comparator.

---
 rtl/seq_dtree_classifier.sv | 172 +++++++++++++++++
 tb/tb_seq_dtree_classifier.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_dtree_classifier.sv
// rtl/seq_dtree_classifier.sv - time-multiplexed runtime-programmable decision-tree classifier
//
// Walks a register-based node table one node per clock with a single shared
// comparator and returns the class index of the leaf it reaches.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (also clears the node table)
//   in_valid/ready  feature-vector handshake; in_feat holds N_FEAT packed features
//   out_valid/ready result handshake; out_class = class index, out_err = walk aborted
//   cfg_we/addr/data node-table write port, honoured only while cfg_busy is low
//
// Node word, MSB to LSB: internal, feat_sel, shift, thr, left, right.
// Leaf class is thr[CLASS_W-1:0]; internal nodes test (feat >> shift) <= thr.
module seq_dtree_classifier #(
  parameter int N_FEAT    = 5,
  parameter int FEAT_W    = 8,
  parameter int N_NODES   = 32,
  parameter int NODE_W    = $clog2(N_NODES),
  parameter int CLASS_W   = 5,
  parameter int MAX_DEPTH = 8,
  parameter int FSEL_W    = $clog2(N_FEAT),
  parameter int SH_W      = $clog2(FEAT_W),
  parameter int NW        = 1 + FSEL_W + SH_W + FEAT_W + 2 * NODE_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] in_feat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       out_class,
  output logic                     out_err,
  input  logic                     cfg_we,
  input  logic [NODE_W-1:0]        cfg_addr,
  input  logic [NW-1:0]            cfg_data,
  output logic                     cfg_busy
);

  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [NODE_W-1:0]          node_q, node_d;
  logic [DEPTH_W-1:0]         depth_q, depth_d;
  logic [N_FEAT*FEAT_W-1:0]   feat_q, feat_d;
  logic [CLASS_W-1:0]         class_q, class_d;
  logic                       err_q, err_d;
  logic [NW-1:0]              table_q [N_NODES];
  logic [NW-1:0]              table_d [N_NODES];

  // Decoded fields of the node currently being evaluated.
  logic [NW-1:0]     word;
  logic              w_internal;
  logic [FSEL_W-1:0] w_fsel;
  logic [SH_W-1:0]   w_shift;
  logic [FEAT_W-1:0] w_thr;
  logic [NODE_W-1:0] w_left;
  logic [NODE_W-1:0] w_right;

  logic [FEAT_W-1:0] sel_feat;
  logic [FEAT_W-1:0] shifted;
  logic              go_left;
  logic [NODE_W-1:0] child;
  logic              fsel_bad;
  logic              child_bad;
  logic              depth_hit;
  logic              addr_ok;

  always_comb begin
    word       = table_q[node_q];
    w_internal = word[NW-1];
    w_fsel     = word[NW-2 -: FSEL_W];
    w_shift    = word[NW-2-FSEL_W -: SH_W];
    w_thr      = word[2*NODE_W +: FEAT_W];
    w_left     = word[NODE_W +: NODE_W];
    w_right    = word[0 +: NODE_W];
  end

  // Feature mux: an out-of-range select yields zero here, but the walk
  // flags it as an error before the comparison result is ever used.
  always_comb begin
    sel_feat = '0;
    for (int i = 0; i < N_FEAT; i++) begin
      if (w_fsel == FSEL_W'(i)) sel_feat = feat_q[i*FEAT_W +: FEAT_W];
    end
  end

  always_comb begin
    shifted   = sel_feat >> w_shift;
    go_left   = (shifted <= w_thr);
    child     = go_left ? w_left : w_right;
    // Widened by one bit so the bounds stay meaningful for any parameter set.
    fsel_bad  = ({1'b0, w_fsel} >= (FSEL_W + 1)'(N_FEAT));
    child_bad = ({1'b0, child} >= (NODE_W + 1)'(N_NODES));
    depth_hit = (depth_q == DEPTH_W'(MAX_DEPTH));
    addr_ok   = ({1'b0, cfg_addr} < (NODE_W + 1)'(N_NODES));
  end

  always_comb begin
    state_d = state_q;
    node_d  = node_q;
    depth_d = depth_q;
    feat_d  = feat_q;
    class_d = class_q;
    err_d   = err_q;
    for (int i = 0; i < N_NODES; i++) table_d[i] = table_q[i];

    case (state_q)
      IDLE: begin
        // A write in the acceptance cycle lands before the first WALK read.
        if (cfg_we && addr_ok) table_d[cfg_addr] = cfg_data;
        if (in_valid) begin
          feat_d  = in_feat;
          node_d  = '0;
          depth_d = '0;
          state_d = WALK;
        end
      end
      WALK: begin
        if (!w_internal) begin
          class_d = w_thr[CLASS_W-1:0];
          err_d   = 1'b0;
          state_d = DONE;
        end else if (fsel_bad || child_bad || depth_hit) begin
          class_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          node_d  = child;
          depth_d = depth_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      node_q  <= '0;
      depth_q <= '0;
      feat_q  <= '0;
      class_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < N_NODES; i++) table_q[i] <= '0;
    end else begin
      state_q <= state_d;
      node_q  <= node_d;
      depth_q <= depth_d;
      feat_q  <= feat_d;
      class_q <= class_d;
      err_q   <= err_d;
      for (int i = 0; i < N_NODES; i++) table_q[i] <= table_d[i];
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign cfg_busy  = (state_q != IDLE);
  assign out_class = class_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_seq_dtree_classifier.sv
// tb/tb_seq_dtree_classifier.sv - self-checking bench for seq_dtree_classifier
module tb_seq_dtree_classifier;

  localparam int N_FEAT  = 5;
  localparam int FEAT_W  = 8;
  localparam int NODE_W  = 5;
  localparam int CLASS_W = 5;
  localparam int NW      = 25;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic [N_FEAT*FEAT_W-1:0] in_feat;
  logic                     out_valid;
  logic                     out_ready;
  logic [CLASS_W-1:0]       out_class;
  logic                     out_err;
  logic                     cfg_we;
  logic [NODE_W-1:0]        cfg_addr;
  logic [NW-1:0]            cfg_data;
  logic                     cfg_busy;

  seq_dtree_classifier dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_feat   (in_feat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_err   (out_err),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_busy  (cfg_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cls;
    int err;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic logic [NW-1:0] nd_int(input int fs, input int sh, input int thr,
                                           input int l, input int r);
    return {1'b1, 3'(fs), 3'(sh), 8'(thr), 5'(l), 5'(r)};
  endfunction

  function automatic logic [NW-1:0] nd_leaf(input int c);
    return {1'b0, 3'b0, 3'b0, 8'(c), 10'b0};
  endfunction

  task automatic push_exp(input int c, input int e, input int lat);
    exp_t x;
    x.cls = c;
    x.err = e;
    x.lat = lat;
    sb.push_back(x);
  endtask

  task automatic cfg_write(input int addr, input logic [NW-1:0] data);
    cfg_we   = 1'b1;
    cfg_addr = 5'(addr);
    cfg_data = data;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  // wmode: 0 no write, 1 write in the acceptance cycle, 2 write during WALK.
  task automatic run(input string tag, input logic [39:0] f, input int hold,
                     input int wmode, input int waddr, input logic [NW-1:0] wdata);
    int          n;
    exp_t        e;
    logic [63:0] junk;
    chk($sformatf("%s.in_ready_idle", tag), 32'(in_ready), 32'd1);
    in_feat  = f;
    in_valid = 1'b1;
    if (wmode == 1) begin
      cfg_we   = 1'b1;
      cfg_addr = 5'(waddr);
      cfg_data = wdata;
    end
    @(negedge clk);
    n        = 1;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    junk     = {$urandom, $urandom};
    in_feat  = junk[39:0];
    while (!out_valid && n < 40) begin
      if (wmode == 2 && n == 1) begin
        chk($sformatf("%s.cfg_busy_walk", tag), 32'(cfg_busy), 32'd1);
        cfg_we   = 1'b1;
        cfg_addr = 5'(waddr);
        cfg_data = wdata;
      end else begin
        cfg_we = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    cfg_we = 1'b0;
    chk($sformatf("%s.out_valid", tag), 32'(out_valid), 32'd1);
    if (sb.size() == 0) begin
      chk($sformatf("%s.scoreboard_empty", tag), 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk($sformatf("%s.latency", tag), 32'(n), 32'(e.lat));
      chk($sformatf("%s.class", tag), 32'(out_class), 32'(e.cls));
      chk($sformatf("%s.err", tag), 32'(out_err), 32'(e.err));
      chk($sformatf("%s.in_ready_done", tag), 32'(in_ready), 32'd0);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk($sformatf("%s.hold_valid", tag), 32'(out_valid), 32'd1);
        chk($sformatf("%s.hold_class", tag), 32'(out_class), 32'(e.cls));
        chk($sformatf("%s.hold_in_ready", tag), 32'(in_ready), 32'd0);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk($sformatf("%s.valid_drop", tag), 32'(out_valid), 32'd0);
    chk($sformatf("%s.back_idle", tag), 32'(in_ready), 32'd1);
  endtask

  task automatic load_chain();
    for (int i = 0; i < 5; i++) cfg_write(i, nd_int(i, i, 255, i + 1, 31));
    cfg_write(5, nd_leaf(9));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_feat   = '0;
    out_ready = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.out_class", 32'(out_class), 32'd0);
    chk("reset.out_err", 32'(out_err), 32'd0);
    chk("reset.cfg_busy", 32'(cfg_busy), 32'd0);

    push_exp(0, 0, 2);
    run("empty_table", 40'h12_3456_789A, 0, 0, 0, '0);

    cfg_write(0, nd_int(4, 6, 0, 1, 2));
    cfg_write(1, nd_leaf(7));
    cfg_write(2, nd_leaf(24));
    push_exp(7, 0, 3);
    run("split_true", {8'h3F, 32'hA5A5_A5A5}, 0, 0, 0, '0);
    push_exp(24, 0, 3);
    run("split_false", {8'h40, 32'h1234_5678}, 5, 0, 0, '0);

    load_chain();
    push_exp(9, 0, 7);
    run("chain5", 40'hFF_FFFF_FFFF, 0, 0, 0, '0);

    cfg_write(0, nd_int(0, 0, 255, 0, 0));
    push_exp(0, 1, 10);
    run("self_loop", 40'h00_0000_0011, 0, 0, 0, '0);

    cfg_write(0, nd_int(6, 0, 0, 1, 2));
    push_exp(0, 1, 2);
    run("bad_fsel", 40'h00_0000_0000, 0, 0, 0, '0);

    cfg_write(0, nd_int(0, 0, 255, 1, 31));
    push_exp(9, 0, 7);
    run("walk_write", 40'h01_0203_0405, 0, 2, 5, nd_leaf(3));
    push_exp(9, 0, 7);
    run("walk_write_rerun", 40'h01_0203_0405, 0, 0, 0, '0);

    push_exp(17, 0, 2);
    run("accept_write", 40'h01_0203_0405, 0, 1, 0, nd_leaf(17));

    cfg_write(0, nd_int(0, 0, 255, 1, 31));
    in_feat  = 40'h55_5555_5555;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("midreset.busy_before", 32'(cfg_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset.out_valid", 32'(out_valid), 32'd0);
    chk("midreset.in_ready", 32'(in_ready), 32'd1);
    chk("midreset.cfg_busy", 32'(cfg_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_exp(0, 0, 2);
    run("after_reset", 40'h55_5555_5555, 0, 0, 0, '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
